// File: rtl/logic_op_unit.sv
// logic_op_unit: debounced-button mode selector applying one of eight bitwise ops to synchronised switch banks
module logic_op_unit #(
  parameter int WIDTH = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             btn_mode,
  output logic [WIDTH-1:0] y,
  output logic [2:0]       mode,
  output logic             valid
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] RUN = 1'b1;
  logic [WIDTH-1:0] a_s1, a_s, b_s1, b_s, op_y;
  logic btn_s1, btn_s, btn_db;
  logic [CW-1:0] cnt;
  logic [1:0] fill_cnt;
  logic [0:0] state;
  always_comb begin
    op_y = '0;
    case (mode)
      3'd0: op_y = a_s & b_s;
      3'd1: op_y = a_s | b_s;
      3'd2: op_y = a_s ^ b_s;
      3'd3: op_y = ~(a_s & b_s);
      3'd4: op_y = ~(a_s | b_s);
      3'd5: op_y = ~(a_s ^ b_s);
      3'd6: op_y = a_s;
      default: op_y = ~a_s;
    endcase
  end
  assign valid = (state == RUN);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_s1 <= '0;
      a_s <= '0;
      b_s1 <= '0;
      b_s <= '0;
      btn_s1 <= 1'b0;
      btn_s <= 1'b0;
      btn_db <= 1'b0;
      cnt <= '0;
      mode <= 3'd0;
      y <= '0;
      fill_cnt <= 2'd0;
      state <= FILL;
    end else begin
      a_s1 <= a;
      a_s <= a_s1;
      b_s1 <= b;
      b_s <= b_s1;
      btn_s1 <= btn_mode;
      btn_s <= btn_s1;
      // a change is accepted only after DEBOUNCE_CYCLES consecutive differing cycles
      if (btn_s == btn_db) cnt <= '0;
      else if (cnt == LAST) begin
        cnt <= '0;
        btn_db <= btn_s;
        if (btn_s) mode <= mode + 3'd1;
      end else cnt <= cnt + 1'b1;
      y <= op_y;
      if (state == FILL) begin
        fill_cnt <= fill_cnt + 2'd1;
        if (fill_cnt == 2'd2) state <= RUN;
      end
    end
  end
endmodule
